// File: rtl/lr35902_sio_pkg.sv
// ============================================================================
// Module   : lr35902_sio_pkg
// Brief    : Shared constants and types for the LR35902 link-cable peer.
// Revision : 1.0
// ============================================================================
`default_nettype none

package lr35902_sio_pkg;
    localparam logic [7:0] SIO_IDLE_BYTE = 8'hff;
    localparam int         SIO_BITS      = 8;
    localparam int         SIO_CNT_W     = $clog2(SIO_BITS);
    localparam int         SIO_TMO_W     = 16;

    typedef logic [SIO_CNT_W-1:0] sio_cnt_t;
    typedef logic [SIO_BITS-1:0]  sio_byte_t;
endpackage

`default_nettype wire

// File: rtl/lr35902_sio_peer_if.sv
// ============================================================================
// Module   : lr35902_sio_peer_if
// Brief    : Host-side valid/ready byte interface of the link-cable peer.
// Revision : 1.0
// ============================================================================
`default_nettype none

interface lr35902_sio_peer_if;
    import lr35902_sio_pkg::*;

    sio_byte_t tx_data;
    logic      tx_valid;
    logic      tx_ready;
    sio_byte_t rx_data;
    logic      rx_valid;
    logic      rx_ready;
    logic      overrun;
    logic      busy;

    modport master (
        output tx_data, tx_valid, rx_ready,
        input  tx_ready, rx_data, rx_valid, overrun, busy
    );

    modport slave (
        input  tx_data, tx_valid, rx_ready,
        output tx_ready, rx_data, rx_valid, overrun, busy
    );
endinterface

`default_nettype wire

// File: rtl/lr35902_sio_sync.sv
// ============================================================================
// Module   : lr35902_sio_sync
// Brief    : 2-FF synchronizer with optional rise/fall detection stage.
// Revision : 1.0
// ============================================================================
`default_nettype none

module lr35902_sio_sync #(
    parameter bit EDGES     = 1'b0,
    parameter bit RESET_VAL = 1'b1
) (
    input  wire logic clk,
    input  wire logic reset_n,
    input  wire logic din,
    output logic      dout,
    output logic      rise,
    output logic      fall
);
    logic [1:0] r_sync;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_sync <= {2{RESET_VAL}};
        end else begin
            r_sync <= {r_sync[0], din};
        end
    end

    assign dout = r_sync[1];

    generate
        if (EDGES) begin : g_edge
            logic r_dly;

            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    r_dly <= RESET_VAL;
                end else begin
                    r_dly <= r_sync[1];
                end
            end

            assign rise = r_sync[1] & ~r_dly;
            assign fall = ~r_sync[1] & r_dly;
        end else begin : g_no_edge
            assign rise = 1'b0;
            assign fall = 1'b0;
        end
    endgenerate
endmodule

`default_nettype wire

// File: rtl/lr35902_sio_peer.sv
// ============================================================================
// Module   : lr35902_sio_peer
// Brief    : LR35902 serial link-cable partner (console is clock master).
//            Define LR35902_SIO_PEER_TIMEOUT_EN to abort bytes stalled mid-way.
// Revision : 1.0
// ============================================================================
`default_nettype none

module lr35902_sio_peer
    import lr35902_sio_pkg::*;
#(
    parameter logic [15:0] TIMEOUT = 16'hffff
) (
    input  wire logic            clk,
    input  wire logic            reset_n,
    input  wire logic            sck_in,
    input  wire logic            sout_in,
    output logic                 sin_out,
    lr35902_sio_peer_if.slave    host
);
    localparam sio_cnt_t LAST_BIT = sio_cnt_t'(SIO_BITS - 1);

    logic      w_sck_rise;
    logic      w_sck_fall;
    logic      w_sout;
    logic      w_unused_sck_lvl;
    logic      w_unused_sout_rise;
    logic      w_unused_sout_fall;
    logic      w_tx_fire;
    logic      w_busy;
    logic      w_abort;

    sio_byte_t r_tx_shift;
    sio_byte_t r_rx_shift;
    sio_byte_t r_hold;
    sio_byte_t r_rx_data;
    sio_cnt_t  r_bit_cnt;
    logic      r_hold_full;
    logic      r_rx_valid;
    logic      r_overrun;

    lr35902_sio_sync #(.EDGES(1'b1), .RESET_VAL(1'b1)) u_sck_sync (
        .clk     (clk),
        .reset_n (reset_n),
        .din     (sck_in),
        .dout    (w_unused_sck_lvl),
        .rise    (w_sck_rise),
        .fall    (w_sck_fall)
    );

    lr35902_sio_sync #(.EDGES(1'b0), .RESET_VAL(1'b1)) u_sout_sync (
        .clk     (clk),
        .reset_n (reset_n),
        .din     (sout_in),
        .dout    (w_sout),
        .rise    (w_unused_sout_rise),
        .fall    (w_unused_sout_fall)
    );

    assign w_busy    = (r_bit_cnt != '0);
    assign w_tx_fire = host.tx_valid & ~r_hold_full;

`ifdef LR35902_SIO_PEER_TIMEOUT_EN
    logic [SIO_TMO_W-1:0] r_idle_cnt;

    // Any SCK activity re-arms the watchdog; it only runs while a byte is open.
    assign w_abort = w_busy & ~w_sck_rise & ~w_sck_fall & (r_idle_cnt == TIMEOUT);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_idle_cnt <= '0;
        end else if (w_sck_rise || w_sck_fall || w_abort) begin
            r_idle_cnt <= '0;
        end else if (w_busy) begin
            r_idle_cnt <= r_idle_cnt + 1'b1;
        end
    end
`else
    logic w_unused_timeout;

    assign w_abort          = 1'b0;
    assign w_unused_timeout = ^TIMEOUT;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_tx_shift  <= SIO_IDLE_BYTE;
            r_rx_shift  <= '0;
            r_hold      <= '0;
            r_rx_data   <= '0;
            r_bit_cnt   <= '0;
            r_hold_full <= 1'b0;
            r_rx_valid  <= 1'b0;
            r_overrun   <= 1'b0;
        end else begin
            r_overrun <= 1'b0;

            if (r_rx_valid && host.rx_ready) begin
                r_rx_valid <= 1'b0;
            end

            // Handshake only fires with hold empty, so it never races a reload.
            if (w_tx_fire) begin
                r_hold      <= host.tx_data;
                r_hold_full <= 1'b1;
            end

            if (w_abort) begin
                r_bit_cnt  <= '0;
                r_rx_shift <= '0;
                if (r_hold_full) begin
                    r_tx_shift  <= r_hold;
                    r_hold_full <= 1'b0;
                end else begin
                    r_tx_shift <= SIO_IDLE_BYTE;
                end
            end else if (w_sck_rise) begin
                r_rx_shift <= {r_rx_shift[SIO_BITS-2:0], w_sout};
                r_bit_cnt  <= r_bit_cnt + 1'b1;
                if (r_bit_cnt == LAST_BIT) begin
                    r_rx_data  <= {r_rx_shift[SIO_BITS-2:0], w_sout};
                    r_rx_valid <= 1'b1;
                    r_overrun  <= r_rx_valid & ~host.rx_ready;
                    if (r_hold_full) begin
                        r_tx_shift  <= r_hold;
                        r_hold_full <= 1'b0;
                    end else begin
                        r_tx_shift <= SIO_IDLE_BYTE;
                    end
                end
            end else begin
                // First fall of a byte keeps the freshly loaded MSB on the line.
                if (w_sck_fall && w_busy) begin
                    r_tx_shift <= {r_tx_shift[SIO_BITS-2:0], 1'b1};
                end
                if (!w_busy && r_hold_full) begin
                    r_tx_shift  <= r_hold;
                    r_hold_full <= 1'b0;
                end
            end
        end
    end

    assign sin_out       = r_tx_shift[SIO_BITS-1];
    assign host.tx_ready = ~r_hold_full;
    assign host.rx_data  = r_rx_data;
    assign host.rx_valid = r_rx_valid;
    assign host.overrun  = r_overrun;
    assign host.busy     = w_busy;
endmodule

`default_nettype wire

// File: tb/tb_lr35902_sio_peer.sv
// ============================================================================
// Module   : tb_lr35902_sio_peer
// Brief    : Self-checking bench: console model plus rx/tx scoreboards.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_lr35902_sio_peer;
    logic clk     = 1'b0;
    logic reset_n = 1'b0;
    logic sck_in  = 1'b1;
    logic sout_in = 1'b1;
    logic sin_out;

    lr35902_sio_peer_if host_if();

    lr35902_sio_peer #(.TIMEOUT(16'd100)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .sck_in  (sck_in),
        .sout_in (sout_in),
        .sin_out (sin_out),
        .host    (host_if)
    );

    always #5 clk = ~clk;

    int         n_checks = 0;
    int         n_errors = 0;
    int         ovr_cnt  = 0;
    logic [7:0] rx_exp[$];
    logic [7:0] tx_exp[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Host consumer side of the rx scoreboard.
    always @(negedge clk) begin
        if (reset_n && host_if.overrun) ovr_cnt++;
        if (reset_n && host_if.rx_valid && host_if.rx_ready) begin
            if (rx_exp.size() == 0) check("rx_extra", 32'(rx_exp.size()), 32'd1);
            else                    check("rx_data", {24'd0, host_if.rx_data}, {24'd0, rx_exp.pop_front()});
        end
    end

    // Console: drives SOUT on the falling edge, samples SIN just before rising.
    task automatic xfer(input logic [7:0] dout, input int nbits, input bit late_wr,
                        input logic [7:0] late_byte, output logic [7:0] din);
        din = 8'hff;
        for (int i = 0; i < nbits; i++) begin
            sck_in  = 1'b0;
            sout_in = dout[7-i];
            repeat (10) @(posedge clk);
            #1;
            din[7-i] = sin_out;
            sck_in   = 1'b1;
            if (late_wr && i == 7) begin
                repeat (2) @(posedge clk);
                #1;
                host_if.tx_data  = late_byte;
                host_if.tx_valid = 1'b1;
                @(posedge clk);
                #1;
                host_if.tx_valid = 1'b0;
                repeat (7) @(posedge clk);
            end else begin
                repeat (10) @(posedge clk);
            end
            #1;
        end
    endtask

    task automatic send(input logic [7:0] dout);
        logic [7:0] got;
        xfer(dout, 8, 1'b0, 8'h00, got);
        check("console_rx", {24'd0, got}, {24'd0, tx_exp.pop_front()});
    endtask

    task automatic host_write(input logic [7:0] b);
        logic rdy;
        rdy = 1'b0;
        host_if.tx_data  = b;
        host_if.tx_valid = 1'b1;
        for (int k = 0; k < 50 && !rdy; k++) begin
            @(negedge clk);
            rdy = host_if.tx_ready;
            @(posedge clk);
            #1;
        end
        host_if.tx_valid = 1'b0;
        check("tx_handshake", {31'd0, rdy}, 32'd1);
    endtask

    initial begin
        logic [7:0] got;
        int         ovr0;
        int         waited;

        host_if.tx_data  = 8'h00;
        host_if.tx_valid = 1'b0;
        host_if.rx_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_sin",      {31'd0, sin_out},          32'd1);
        check("rst_tx_ready", {31'd0, host_if.tx_ready}, 32'd1);
        check("rst_rx_valid", {31'd0, host_if.rx_valid}, 32'd0);
        check("rst_rx_data",  {24'd0, host_if.rx_data}, 32'd0);
        check("rst_overrun",  {31'd0, host_if.overrun},  32'd0);
        check("rst_busy",     {31'd0, host_if.busy},     32'd0);
        reset_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;

        // Empty hold: console sees all ones, byte left pending
        tx_exp.push_back(8'hff);
        rx_exp.push_back(8'ha5);
        send(8'ha5);
        repeat (5) @(posedge clk);
        #1;
        check("t1_rx_valid", {31'd0, host_if.rx_valid}, 32'd1);
        check("t1_rx_data",  {24'd0, host_if.rx_data},  32'h a5);
        check("t1_overrun",  32'(ovr_cnt),              32'd0);
        check("t1_busy",     {31'd0, host_if.busy},     32'd0);
        host_if.rx_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("t1_drained", 32'(rx_exp.size()), 32'd0);

        // Preloaded byte goes out MSB first
        host_write(8'h3c);
        repeat (3) @(posedge clk);
        #1;
        check("t2_tx_ready", {31'd0, host_if.tx_ready}, 32'd1);
        check("t2_sin_msb",  {31'd0, sin_out},          32'd0);
        tx_exp.push_back(8'h3c);
        rx_exp.push_back(8'hc3);
        send(8'hc3);

        // Overrun: first byte is overwritten unread
        host_if.rx_ready = 1'b0;
        ovr0 = ovr_cnt;
        tx_exp.push_back(8'hff);
        tx_exp.push_back(8'hff);
        rx_exp.push_back(8'h22);
        send(8'h11);
        check("t3_no_ovr_first", 32'(ovr_cnt - ovr0), 32'd0);
        send(8'h22);
        repeat (4) @(posedge clk);
        #1;
        check("t3_ovr_once", 32'(ovr_cnt - ovr0),      32'd1);
        check("t3_rx_data",  {24'd0, host_if.rx_data}, 32'h22);
        host_if.rx_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;

        // Host write coincides with the 8th rise
        host_write(8'h77);
        repeat (3) @(posedge clk);
        #1;
        tx_exp.push_back(8'h77);
        tx_exp.push_back(8'h81);
        rx_exp.push_back(8'h5a);
        rx_exp.push_back(8'h69);
        xfer(8'h5a, 8, 1'b1, 8'h81, got);
        check("t4_current", {24'd0, got}, {24'd0, tx_exp.pop_front()});
        check("t4_tx_ready", {31'd0, host_if.tx_ready}, 32'd1);
        send(8'h69);

        // Reset after 4 bits
        host_write(8'hc7);
        repeat (3) @(posedge clk);
        #1;
        xfer(8'h0f, 4, 1'b0, 8'h00, got);
        check("t5_busy_mid", {31'd0, host_if.busy}, 32'd1);
        check("t5_sin_mid",  {31'd0, sin_out},      32'd0);
        reset_n = 1'b0;
        #1;
        check("t5_sin",      {31'd0, sin_out},          32'd1);
        check("t5_busy",     {31'd0, host_if.busy},     32'd0);
        check("t5_tx_ready", {31'd0, host_if.tx_ready}, 32'd1);
        check("t5_rx_valid", {31'd0, host_if.rx_valid}, 32'd0);
        check("t5_rx_data",  {24'd0, host_if.rx_data},  32'd0);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        tx_exp.push_back(8'hff);
        rx_exp.push_back(8'h96);
        send(8'h96);

`ifdef LR35902_SIO_PEER_TIMEOUT_EN
        // Stalled byte is abandoned by the watchdog
        xfer(8'he0, 3, 1'b0, 8'h00, got);
        check("t6_busy", {31'd0, host_if.busy}, 32'd1);
        waited = 0;
        while (host_if.busy && waited < 300) begin
            @(posedge clk);
            #1;
            waited++;
        end
        check("t6_abort_time", {31'd0, (waited >= 85 && waited <= 110)}, 32'd1);
        check("t6_no_rx",      {31'd0, host_if.rx_valid},               32'd0);
        tx_exp.push_back(8'hff);
        rx_exp.push_back(8'h4b);
        send(8'h4b);
`else
        waited = 0;
`endif

        repeat (5) @(posedge clk);
        #1;
        check("rx_all_seen", 32'(rx_exp.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

`default_nettype wire
